// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the user-project Wishbone interconnect.
//   wb_mux_state_t : interconnect FSM state encoding
//   WB_DAT_W       : Wishbone data width
//   WB_SEL_W       : Wishbone byte-select width
//   WB_ERR_DATA    : read data returned with a bus error
package wb_pkg;

   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } wb_mux_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: cycle counter that watches an outstanding slave request.
// Only built when WB_TIMEOUT_EN is defined.
//   clk_i, rst_n : clock, asynchronous active-low reset
//   clr          : return the count to zero
//   en           : count one more waiting cycle
//   tc           : high in the LIMIT-th counted cycle, so the owner can
//                  leave on the edge that would otherwise make count == LIMIT
module wb_timeout_cnt
   import wb_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + 1'b1;
      end
   end

   // tc is decoded from the count alone so it never loops back through en.
   assign tc = (count_q == LAST);

endmodule

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: single-master, N-slave Wishbone classic interconnect.
// Decodes the slave index from m0_wb_adr_i[SEL_LSB +: IDX_W], registers the
// request, drives exactly one slave and registers the response back.
// Unmapped indices (and, with WB_TIMEOUT_EN defined, hung slaves) end in a
// one-cycle bus error so the master never stalls forever.
//   clk_i, rst_n          : clock, asynchronous active-low reset
//   m0_wb_*_i             : master request (dat, adr, sel, we, cyc, stb)
//   m0_wb_dat_o/ack_o/err_o : registered response, ack/err one-cycle pulses
//   s_wb_dat_i, s_wb_ack_i  : slave k read data at [32k+31:32k], acks
//   s_wb_*_o              : per-slave request fields, zero on unselected slaves
// Build option: define WB_TIMEOUT_EN to add the TIMEOUT_CYC slave timeout.
module wb_slave_mux
   import wb_pkg::*;
#(
   parameter int NUM_SLAVES  = 4,
   parameter int SEL_LSB     = 12,
   parameter int SLV_ADR_W   = 9,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                             clk_i,
   input  logic                             rst_n,
   input  logic [WB_DAT_W-1:0]              m0_wb_dat_i,
   input  logic [31:0]                      m0_wb_adr_i,
   input  logic [WB_SEL_W-1:0]              m0_wb_sel_i,
   input  logic                             m0_wb_we_i,
   input  logic                             m0_wb_cyc_i,
   input  logic                             m0_wb_stb_i,
   output logic [WB_DAT_W-1:0]              m0_wb_dat_o,
   output logic                             m0_wb_ack_o,
   output logic                             m0_wb_err_o,
   input  logic [NUM_SLAVES*WB_DAT_W-1:0]   s_wb_dat_i,
   input  logic [NUM_SLAVES-1:0]            s_wb_ack_i,
   output logic [NUM_SLAVES*WB_DAT_W-1:0]   s_wb_dat_o,
   output logic [NUM_SLAVES*SLV_ADR_W-1:0]  s_wb_adr_o,
   output logic [NUM_SLAVES*WB_SEL_W-1:0]   s_wb_sel_o,
   output logic [NUM_SLAVES-1:0]            s_wb_we_o,
   output logic [NUM_SLAVES-1:0]            s_wb_cyc_o,
   output logic [NUM_SLAVES-1:0]            s_wb_stb_o
);

   // state | meaning
   // IDLE  | waiting for cyc & stb from the master
   // REQ   | request presented to the selected slave, waiting for its ack
   // RESP  | ack or err pulse to the master, all slave strobes low

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [IDX_W:0] NUM_SLV_V = (IDX_W + 1)'(NUM_SLAVES);

   wb_mux_state_t         state_q, state_d;
   logic [WB_DAT_W-1:0]   dat_q;
   logic [SLV_ADR_W-1:0]  adr_q;
   logic [WB_SEL_W-1:0]   sel_q;
   logic                  we_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  ack_q, err_q;
   logic [WB_DAT_W-1:0]   rdat_q;

   logic                  capture, ack_d, err_d, rdat_ld;
   logic [WB_DAT_W-1:0]   rdat_d;
   logic [IDX_W-1:0]      req_idx;
   logic                  req_mapped;
   logic                  sel_ack;
   logic [WB_DAT_W-1:0]   sel_dat;
   logic                  unused_bits;

   assign req_idx     = m0_wb_adr_i[SEL_LSB +: IDX_W];
   assign req_mapped  = ({1'b0, req_idx} < NUM_SLV_V);
   // Only a slice of the master address is decoded; fold the rest away.
   assign unused_bits = ^m0_wb_adr_i;

`ifdef WB_TIMEOUT_EN
   logic cnt_clr, cnt_en, cnt_tc;

   wb_timeout_cnt #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   // Loop rather than a variable index: with a non-power-of-two slave count
   // the index register can encode slaves that do not exist.
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            sel_ack = s_wb_ack_i[k];
            sel_dat = s_wb_dat_i[k*WB_DAT_W +: WB_DAT_W];
         end
      end
   end

   always_comb begin
      s_wb_dat_o = '0;
      s_wb_adr_o = '0;
      s_wb_sel_o = '0;
      s_wb_we_o  = '0;
      s_wb_cyc_o = '0;
      s_wb_stb_o = '0;
      if (state_q == REQ) begin
         for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
               s_wb_dat_o[k*WB_DAT_W +: WB_DAT_W]   = dat_q;
               s_wb_adr_o[k*SLV_ADR_W +: SLV_ADR_W] = adr_q;
               s_wb_sel_o[k*WB_SEL_W +: WB_SEL_W]   = sel_q;
               s_wb_we_o[k]  = we_q;
               s_wb_cyc_o[k] = 1'b1;
               s_wb_stb_o[k] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_ld = 1'b0;
      rdat_d  = WB_ERR_DATA;
`ifdef WB_TIMEOUT_EN
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (m0_wb_cyc_i && m0_wb_stb_i) begin
               capture = 1'b1;
               if (req_mapped) begin
                  state_d = REQ;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdat_ld = 1'b1;
               end
            end
         end
         REQ: begin
`ifdef WB_TIMEOUT_EN
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
`endif
            // A master that has walked away must not receive a late ack.
            if (!m0_wb_cyc_i) begin
               state_d = IDLE;
            end else if (sel_ack) begin
               state_d = RESP;
               ack_d   = 1'b1;
               rdat_ld = 1'b1;
               rdat_d  = sel_dat;
`ifdef WB_TIMEOUT_EN
            end else if (cnt_tc) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdat_ld = 1'b1;
`endif
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dat_q   <= '0;
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         if (capture) begin
            dat_q <= m0_wb_dat_i;
            adr_q <= m0_wb_adr_i[SLV_ADR_W+1:2];
            sel_q <= m0_wb_sel_i;
            we_q  <= m0_wb_we_i;
            idx_q <= req_idx;
         end
         if (rdat_ld) begin
            rdat_q <= rdat_d;
         end
      end
   end

   assign m0_wb_dat_o = rdat_q;
   assign m0_wb_ack_o = ack_q;
   assign m0_wb_err_o = err_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed bench for wb_slave_mux with three slaves, so that
// index 3 is unmapped. Expected responses are queued at issue time and
// checked by an independent monitor when the DUT acks or errors.
module tb_wb_slave_mux;
   import wb_pkg::*;

   localparam int NS  = 3;
   localparam int AW  = 9;
   localparam int TO  = 8;

   logic                  clk_i = 1'b0;
   logic                  rst_n = 1'b0;
   logic [31:0]           m0_wb_dat_i = '0;
   logic [31:0]           m0_wb_adr_i = '0;
   logic [3:0]            m0_wb_sel_i = '0;
   logic                  m0_wb_we_i  = 1'b0;
   logic                  m0_wb_cyc_i = 1'b0;
   logic                  m0_wb_stb_i = 1'b0;
   logic [31:0]           m0_wb_dat_o;
   logic                  m0_wb_ack_o;
   logic                  m0_wb_err_o;
   logic [NS*32-1:0]      s_wb_dat_i = '0;
   logic [NS-1:0]         s_wb_ack_i = '0;
   logic [NS*32-1:0]      s_wb_dat_o;
   logic [NS*AW-1:0]      s_wb_adr_o;
   logic [NS*4-1:0]       s_wb_sel_o;
   logic [NS-1:0]         s_wb_we_o;
   logic [NS-1:0]         s_wb_cyc_o;
   logic [NS-1:0]         s_wb_stb_o;

   wb_slave_mux #(
      .NUM_SLAVES  (NS),
      .SEL_LSB     (12),
      .SLV_ADR_W   (AW),
      .TIMEOUT_CYC (TO)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .m0_wb_dat_i (m0_wb_dat_i),
      .m0_wb_adr_i (m0_wb_adr_i),
      .m0_wb_sel_i (m0_wb_sel_i),
      .m0_wb_we_i  (m0_wb_we_i),
      .m0_wb_cyc_i (m0_wb_cyc_i),
      .m0_wb_stb_i (m0_wb_stb_i),
      .m0_wb_dat_o (m0_wb_dat_o),
      .m0_wb_ack_o (m0_wb_ack_o),
      .m0_wb_err_o (m0_wb_err_o),
      .s_wb_dat_i  (s_wb_dat_i),
      .s_wb_ack_i  (s_wb_ack_i),
      .s_wb_dat_o  (s_wb_dat_o),
      .s_wb_adr_o  (s_wb_adr_o),
      .s_wb_sel_o  (s_wb_sel_o),
      .s_wb_we_o   (s_wb_we_o),
      .s_wb_cyc_o  (s_wb_cyc_o),
      .s_wb_stb_o  (s_wb_stb_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc_cnt = 0;
   int          resp_cnt = 0;
   int          accept_cyc = 0;

   // Request the current transfer should present on the slave side.
   int          exp_idx = -1;
   logic [AW-1:0] exp_sadr = '0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_sel = '0;
   logic [31:0] exp_wdat = '0;

   // Slave model configuration: ack on the Nth strobed cycle (0 = never),
   // stray[k] holds ack high permanently to prove foreign acks are ignored.
   int          ack_delay[NS];
   logic [31:0] rdata[NS];
   logic        stray[NS];
   int          stb_cnt[NS];

   always @(posedge clk_i) cyc_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   initial begin
      for (int k = 0; k < NS; k++) begin
         ack_delay[k] = 0;
         rdata[k]     = 32'hBAD0_0000 | k;
         stray[k]     = 1'b0;
         stb_cnt[k]   = 0;
      end
      forever begin
         @(negedge clk_i);
         for (int k = 0; k < NS; k++) begin
            s_wb_dat_i[k*32 +: 32] = rdata[k];
            if (s_wb_stb_o[k] && s_wb_cyc_o[k]) begin
               stb_cnt[k]++;
               s_wb_ack_i[k] = stray[k] || (stb_cnt[k] == ack_delay[k]);
            end else begin
               stb_cnt[k]    = 0;
               s_wb_ack_i[k] = stray[k];
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_n) begin
            if (m0_wb_ack_o || m0_wb_err_o) begin
               resp_cnt++;
               check("resp_slave_stb_low", 32'(s_wb_stb_o), 32'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp ack=%0b err=%0b expected none", m0_wb_ack_o, m0_wb_err_o);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_err", 32'(m0_wb_err_o), 32'(e.err));
                  check("resp_ack", 32'(m0_wb_ack_o), 32'(!e.err));
                  check("resp_dat", m0_wb_dat_o, e.dat);
                  check("resp_cycle", cyc_cnt, e.cyc);
               end
            end
            if (|s_wb_stb_o) begin
               if (exp_idx < 0) begin
                  checks++;
                  errors++;
                  $display("FAIL stray_slave_stb actual=%b required=000", s_wb_stb_o);
               end else begin
                  check("slv_stb_sel", 32'(s_wb_stb_o), 32'(1) << exp_idx);
                  check("slv_cyc_sel", 32'(s_wb_cyc_o), 32'(1) << exp_idx);
                  check("slv_adr", 32'(s_wb_adr_o[exp_idx*AW +: AW]), 32'(exp_sadr));
                  check("slv_we", 32'(s_wb_we_o[exp_idx]), 32'(exp_we));
                  check("slv_sel", 32'(s_wb_sel_o[exp_idx*4 +: 4]), 32'(exp_sel));
                  check("slv_dat", s_wb_dat_o[exp_idx*32 +: 32], exp_wdat);
               end
            end
         end
      end
   end

   task automatic start_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] wdat, input int idx, input logic [AW-1:0] sadr,
                            input int delay, input logic [31:0] rdat);
      @(negedge clk_i);
      exp_idx  = idx;
      exp_sadr = sadr;
      exp_we   = we;
      exp_sel  = sel;
      exp_wdat = wdat;
      if (idx >= 0) begin
         ack_delay[idx] = delay;
         rdata[idx]     = rdat;
      end
      accept_cyc  = cyc_cnt + 1;
      m0_wb_adr_i = adr;
      m0_wb_we_i  = we;
      m0_wb_sel_i = sel;
      m0_wb_dat_i = wdat;
      m0_wb_cyc_i = 1'b1;
      m0_wb_stb_i = 1'b1;
   endtask

   task automatic end_req();
      m0_wb_cyc_i = 1'b0;
      m0_wb_stb_i = 1'b0;
      m0_wb_we_i  = 1'b0;
      exp_idx     = -1;
      for (int k = 0; k < NS; k++) ack_delay[k] = 0;
   endtask

   task automatic wait_resp(input int budget);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk_i);
         if (m0_wb_ack_o || m0_wb_err_o) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL resp_wait no ack or err within %0d cycles", budget);
         if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      end
   endtask

   // lat is counted in cycles after the accepting edge: cycle 1 is the
   // cycle that edge starts.
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] wdat, input int idx, input logic [AW-1:0] sadr,
                       input int delay, input logic [31:0] rdat,
                       input logic exp_err, input logic [31:0] exp_dat, input int lat);
      exp_t e;
      start_req(adr, we, sel, wdat, idx, sadr, delay, rdat);
      e.err = exp_err;
      e.dat = exp_dat;
      e.cyc = accept_cyc + lat - 1;
      exp_q.push_back(e);
      wait_resp(50);
      end_req();
   endtask

   initial begin
      int r0;
      #1;
      check("rst_m0_dat", m0_wb_dat_o, 32'h0);
      check("rst_m0_ack", 32'(m0_wb_ack_o), 32'h0);
      check("rst_m0_err", 32'(m0_wb_err_o), 32'h0);
      check("rst_s_stb_cyc", 32'({s_wb_stb_o, s_wb_cyc_o, s_wb_we_o}), 32'h0);
      check("rst_s_adr_sel", 32'({s_wb_adr_o, s_wb_sel_o}) | 32'(|s_wb_adr_o), 32'h0);
      check("rst_s_dat", 32'(|s_wb_dat_o), 32'h0);
      repeat (3) @(negedge clk_i);
      rst_n = 1'b1;

      // Read slave 1, ack on 2nd strobed cycle; slaves 0 and 2 spray acks.
      stray[0] = 1'b1;
      stray[2] = 1'b1;
      xfer(32'h0000_1010, 1'b0, 4'hF, 32'h0, 1, 9'h004, 2, 32'hA5A5_0001,
           1'b0, 32'hA5A5_0001, 3);
      stray[0] = 1'b0;
      stray[2] = 1'b0;

      // Write slave 2; master data shows what the slave returned.
      xfer(32'h0000_2000, 1'b1, 4'b0011, 32'h1234_5678, 2, 9'h000, 1, 32'hDEAD_BEEF,
           1'b0, 32'hDEAD_BEEF, 2);

      // Unmapped index 3.
      xfer(32'h0000_3000, 1'b0, 4'hF, 32'h0, -1, 9'h000, 0, 32'h0,
           1'b1, 32'h0, 1);

      // Back-to-back, high address bits ignored, unmapped again with high bits.
      xfer(32'h0000_0FFC, 1'b0, 4'hF, 32'h0, 0, 9'h1FF, 1, 32'h0BAD_F00D,
           1'b0, 32'h0BAD_F00D, 2);
      xfer(32'h8000_5008, 1'b0, 4'hC, 32'h55AA_55AA, 1, 9'h002, 3, 32'hCAFE_0001,
           1'b0, 32'hCAFE_0001, 4);
      xfer(32'hFFFF_7000, 1'b1, 4'h1, 32'h1111_2222, -1, 9'h000, 0, 32'h0,
           1'b1, 32'h0, 1);

`ifdef WB_TIMEOUT_EN
      // Slave 2 never acks: error in cycle TO+1.
      xfer(32'h0000_2000, 1'b0, 4'hF, 32'h0, 2, 9'h000, 0, 32'h0,
           1'b1, 32'h0, TO + 1);
`else
      // Slave 2 never acks: the request simply stays presented.
      start_req(32'h0000_2000, 1'b0, 4'hF, 32'h0, 2, 9'h000, 0, 32'h0);
      r0 = resp_cnt;
      repeat (20) @(negedge clk_i);
      check("hang_no_resp", resp_cnt, r0);
      check("hang_stb_held", 32'(s_wb_stb_o), 32'h4);
      end_req();
      @(negedge clk_i);
      check("hang_abort_stb", 32'(s_wb_stb_o), 32'h0);
`endif

      // Master abandons a request to slave 1.
      start_req(32'h0000_1010, 1'b0, 4'hF, 32'h0, 1, 9'h004, 0, 32'h0);
      repeat (3) @(negedge clk_i);
      check("abort_stb_before", 32'(s_wb_stb_o), 32'h2);
      r0 = resp_cnt;
      end_req();
      @(negedge clk_i);
      check("abort_stb_after", 32'(s_wb_stb_o), 32'h0);
      repeat (3) @(negedge clk_i);
      check("abort_no_resp", resp_cnt, r0);
      xfer(32'h0000_0004, 1'b0, 4'hF, 32'h0, 0, 9'h001, 1, 32'h0000_0042,
           1'b0, 32'h0000_0042, 2);

      // Reset in the middle of a request to slave 2.
      start_req(32'h0000_2010, 1'b1, 4'hF, 32'h9999_0000, 2, 9'h004, 0, 32'h0);
      repeat (2) @(negedge clk_i);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_m0_dat", m0_wb_dat_o, 32'h0);
      check("mid_rst_m0_ack_err", 32'({m0_wb_ack_o, m0_wb_err_o}), 32'h0);
      check("mid_rst_s_ctl", 32'({s_wb_stb_o, s_wb_cyc_o, s_wb_we_o}), 32'h0);
      check("mid_rst_s_dat", 32'(|s_wb_dat_o) | 32'(|s_wb_adr_o) | 32'(|s_wb_sel_o), 32'h0);
      end_req();
      @(negedge clk_i);
      rst_n = 1'b1;
      xfer(32'h0000_1FFC, 1'b0, 4'hF, 32'h0, 1, 9'h1FF, 1, 32'h7777_8888,
           1'b0, 32'h7777_8888, 2);

      repeat (4) @(negedge clk_i);
      check("queue_drained", exp_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
